// File: rtl/lc3b_split_mem_responder_pkg.sv
// rtl/lc3b_split_mem_responder_pkg.sv - shared types for the split imem/dmem responder
package lc3b_split_mem_responder_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} lc3b_memresp_state_t;
  typedef enum logic {PORT_I, PORT_D} lc3b_mem_port_t;

endpackage

// File: rtl/lc3b_byte_array.sv
// rtl/lc3b_byte_array.sv - byte-addressable storage with word read and masked word write
module lc3b_byte_array
  import lc3b_split_mem_responder_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic [ADDR_W-2:0] raddr,
  output lc3b_word          rdata,
  input  logic              we,
  input  logic [ADDR_W-2:0] waddr,
  input  lc3b_word          wdata,
  input  lc3b_mem_wmask     wmask
);

  logic [7:0] mem [0:2**ADDR_W-1];

  assign rdata = {mem[{raddr, 1'b1}], mem[{raddr, 1'b0}]};

  always_ff @(posedge clk) begin
    if (we) begin
      if (wmask[0]) mem[{waddr, 1'b0}] <= wdata[7:0];
      if (wmask[1]) mem[{waddr, 1'b1}] <= wdata[15:8];
    end
  end

endmodule

// File: rtl/lc3b_split_mem_responder.sv
// rtl/lc3b_split_mem_responder.sv - fixed-latency round-robin responder for split imem/dmem ports
module lc3b_split_mem_responder
  import lc3b_split_mem_responder_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          imem_read,
  input  logic [15:0]   imem_address,
  output lc3b_word      imem_rdata,
  output logic          imem_resp,
  input  logic          dmem_read,
  input  logic          dmem_write,
  input  logic [15:0]   dmem_address,
  input  lc3b_word      dmem_wdata,
  input  lc3b_mem_wmask dmem_byte_enable,
  output lc3b_word      dmem_rdata,
  output logic          dmem_resp
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  lc3b_memresp_state_t state, state_next;
  logic [3:0]          cnt, cnt_next;
  lc3b_mem_port_t      gport, last_grant, sel_port, cur_port;
  logic [ADDR_W-2:0]   gaddr, sel_addr, rd_addr;
  lc3b_word            gwdata, arr_rdata;
  lc3b_mem_wmask       gbe;
  logic                gwrite, cur_write;
  logic                i_live, d_live, grant, load_rd;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^{imem_address, dmem_address};

  always_comb begin
    i_live   = imem_read;
    d_live   = dmem_read | dmem_write;
    sel_port = PORT_I;
    if (i_live && d_live) sel_port = (last_grant == PORT_I) ? PORT_D : PORT_I;
    else if (d_live)      sel_port = PORT_D;
    grant    = (state == IDLE) && (i_live || d_live);
    sel_addr = (sel_port == PORT_D) ? dmem_address[ADDR_W-1:1] : imem_address[ADDR_W-1:1];
  end

  // With LATENCY==1 RESP is entered straight from IDLE, so the live request feeds the read.
  always_comb begin
    rd_addr   = (state == IDLE) ? sel_addr : gaddr;
    cur_port  = (state == IDLE) ? sel_port : gport;
    cur_write = (state == IDLE) ? ((sel_port == PORT_D) && dmem_write) : gwrite;
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    imem_resp  = 1'b0;
    dmem_resp  = 1'b0;
    case (state)
      IDLE: begin
        if (grant) begin
          cnt_next   = CNT_INIT;
          state_next = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) state_next = RESP;
      end
      RESP: begin
        imem_resp  = (gport == PORT_I);
        dmem_resp  = (gport == PORT_D);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    load_rd = (state_next == RESP) && (state != RESP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gport      <= PORT_I;
      last_grant <= PORT_I;
      gaddr      <= '0;
      gwdata     <= '0;
      gbe        <= '0;
      gwrite     <= 1'b0;
      imem_rdata <= '0;
      dmem_rdata <= '0;
    end else begin
      if (grant) begin
        gport  <= sel_port;
        gaddr  <= sel_addr;
        gwdata <= dmem_wdata;
        gbe    <= dmem_byte_enable;
        gwrite <= (sel_port == PORT_D) && dmem_write;
      end
      if (state == RESP) last_grant <= gport;
      if (load_rd && !cur_write) begin
        if (cur_port == PORT_D) dmem_rdata <= arr_rdata;
        else                    imem_rdata <= arr_rdata;
      end
    end
  end

  lc3b_byte_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .raddr (rd_addr),
    .rdata (arr_rdata),
    .we    ((state == RESP) && gwrite),
    .waddr (gaddr),
    .wdata (gwdata),
    .wmask (gbe)
  );

endmodule

// File: tb/tb_lc3b_split_mem_responder.sv
// tb/tb_lc3b_split_mem_responder.sv - directed self-checking bench for the split memory responder
module tb_lc3b_split_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_read, dmem_read, dmem_write;
  logic [15:0] imem_address, dmem_address, dmem_wdata, imem_rdata, dmem_rdata;
  logic [1:0]  dmem_byte_enable;
  logic        imem_resp, dmem_resp;

  logic        i1_read, d1_read, d1_write;
  logic [15:0] i1_address, d1_address, d1_wdata, i1_rdata, d1_rdata;
  logic [1:0]  d1_be;
  logic        i1_resp, d1_resp;

  int tests = 0;
  int fails = 0;
  int both_seen = 0;

  always #5 clk = ~clk;

  lc3b_split_mem_responder #(.ADDR_W(16), .LATENCY(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_read(imem_read), .imem_address(imem_address), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
  );

  lc3b_split_mem_responder #(.ADDR_W(16), .LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .imem_read(i1_read), .imem_address(i1_address), .imem_rdata(i1_rdata), .imem_resp(i1_resp),
    .dmem_read(d1_read), .dmem_write(d1_write), .dmem_address(d1_address),
    .dmem_wdata(d1_wdata), .dmem_byte_enable(d1_be),
    .dmem_rdata(d1_rdata), .dmem_resp(d1_resp)
  );

  always @(negedge clk) if (imem_resp && dmem_resp) both_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input bit is_i, input bit rd, input bit wr, input logic [15:0] a,
                     input logic [15:0] wd, input logic [1:0] be,
                     output int lat, output logic [15:0] rdata);
    lat   = -1;
    rdata = '0;
    if (is_i) begin
      imem_read = 1'b1; imem_address = a;
    end else begin
      dmem_read = rd; dmem_write = wr; dmem_address = a; dmem_wdata = wd; dmem_byte_enable = be;
    end
    for (int k = 0; k < 20 && lat < 0; k++) begin
      @(negedge clk);
      if (is_i ? imem_resp : dmem_resp) begin
        lat   = k;
        rdata = is_i ? imem_rdata : dmem_rdata;
      end
      step();
    end
    imem_read = 1'b0; dmem_read = 1'b0; dmem_write = 1'b0;
  endtask

  initial begin
    int          lat, d_at, i_at, nresp;
    logic [15:0] rv;
    logic [7:0]  seq;

    reset_n = 1'b0;
    imem_read = 0; imem_address = 0; dmem_read = 0; dmem_write = 0;
    dmem_address = 0; dmem_wdata = 0; dmem_byte_enable = 0;
    i1_read = 0; i1_address = 0; d1_read = 0; d1_write = 0; d1_address = 0; d1_wdata = 0; d1_be = 0;
    step();
    @(negedge clk);
    chk("reset_imem_resp", imem_resp, 0);
    chk("reset_dmem_resp", dmem_resp, 0);
    chk("reset_imem_rdata", imem_rdata, 16'h0000);
    chk("reset_dmem_rdata", dmem_rdata, 16'h0000);
    step();
    reset_n = 1'b1;

    // both ports from cycle 0, last_grant=IMEM: dmem (write of the preload) wins first
    imem_read = 1; imem_address = 16'h0010;
    dmem_write = 1; dmem_address = 16'h0010; dmem_wdata = 16'h1234; dmem_byte_enable = 2'b11;
    d_at = -1; i_at = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (dmem_resp) d_at = k;
      if (imem_resp) begin i_at = k; rv = imem_rdata; end
      step();
      if (d_at == k) dmem_write = 0;
      if (i_at == k) imem_read = 0;
    end
    chk("arb_dmem_resp_cycle", d_at, 3);
    chk("arb_imem_resp_cycle", i_at, 7);
    chk("arb_imem_rdata", rv, 16'h1234);

    acc(1, 0, 0, 16'h0010, 0, 0, lat, rv);
    chk("imem_latency", lat, 3);
    chk("imem_rdata", rv, 16'h1234);
    @(negedge clk);
    chk("imem_resp_one_cycle", imem_resp, 0);
    chk("imem_rdata_held", imem_rdata, 16'h1234);
    step();

    // both held for 4 accesses after an imem grant -> D,I,D,I
    imem_read = 1; imem_address = 16'h0010;
    dmem_read = 1; dmem_address = 16'h0010;
    seq = 0; nresp = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (dmem_resp) begin seq = {seq[5:0], 2'b10}; nresp++; end
      if (imem_resp) begin seq = {seq[5:0], 2'b01}; nresp++; end
      step();
    end
    imem_read = 0; dmem_read = 0;
    chk("alt_resp_count", nresp, 4);
    chk("alt_order_DIDI", seq, 8'b10_01_10_01);
    chk("alt_dmem_rdata", dmem_rdata, 16'h1234);

    acc(0, 0, 1, 16'h3000, 16'h0000, 2'b11, lat, rv);
    acc(0, 0, 1, 16'h3000, 16'hBEEF, 2'b10, lat, rv);
    chk("dwrite_latency", lat, 3);
    acc(0, 1, 0, 16'h3000, 0, 0, lat, rv);
    chk("dread_high_byte_only", rv, 16'hBE00);
    acc(0, 0, 1, 16'h3000, 16'hFFFF, 2'b00, lat, rv);
    chk("be00_resp_latency", lat, 3);
    chk("write_keeps_dmem_rdata", dmem_rdata, 16'hBE00);
    acc(0, 1, 0, 16'h3001, 0, 0, lat, rv);
    chk("odd_addr_be00_nochange", rv, 16'hBE00);
    acc(0, 1, 1, 16'h3000, 16'h7777, 2'b11, lat, rv);
    chk("rw_both_keeps_rdata", rv, 16'hBE00);
    acc(0, 1, 0, 16'h3000, 0, 0, lat, rv);
    chk("rw_both_was_write", rv, 16'h7777);
    acc(0, 0, 1, 16'hFFFE, 16'hA55A, 2'b11, lat, rv);
    acc(0, 1, 0, 16'hFFFF, 0, 0, lat, rv);
    chk("top_of_array", rv, 16'hA55A);

    // write aborted by reset in cycle 2
    acc(0, 0, 1, 16'h0100, 16'h5A5A, 2'b11, lat, rv);
    dmem_write = 1; dmem_address = 16'h0100; dmem_wdata = 16'h1111; dmem_byte_enable = 2'b11;
    nresp = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (dmem_resp) nresp++;
      step();
    end
    reset_n = 1'b0;
    @(negedge clk);
    if (dmem_resp) nresp++;
    chk("abort_no_resp", nresp, 0);
    chk("abort_dmem_rdata_reset", dmem_rdata, 16'h0000);
    chk("abort_imem_rdata_reset", imem_rdata, 16'h0000);
    step();
    reset_n = 1'b1; dmem_write = 0;
    step();
    acc(0, 1, 0, 16'h0100, 0, 0, lat, rv);
    chk("abort_old_data", rv, 16'h5A5A);

    // LATENCY=1 instance: preload words then back-to-back fetches
    for (int w = 0; w < 3; w++) begin
      d1_write = 1; d1_be = 2'b11; d1_address = 16'(w * 2);
      d1_wdata = (w == 0) ? 16'h1111 : (w == 1) ? 16'h2222 : 16'h4444;
      step();
      d1_write = 0;
      step();
    end
    i1_read = 1; i1_address = 16'h0000;
    @(negedge clk);
    chk("lat1_c0_no_resp", i1_resp, 0);
    step();
    i1_address = 16'h0004;
    @(negedge clk);
    chk("lat1_c1_resp", i1_resp, 1);
    chk("lat1_c1_rdata", i1_rdata, 16'h1111);
    step();
    i1_address = 16'h0002;
    @(negedge clk);
    chk("lat1_c2_no_resp", i1_resp, 0);
    step();
    @(negedge clk);
    chk("lat1_c3_resp", i1_resp, 1);
    chk("lat1_c3_rdata", i1_rdata, 16'h2222);
    step();
    i1_read = 0;

    chk("never_both_resp", both_seen, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
